// File: rtl/corr_pkg.sv
// Shared definitions for the lag-correlation engine: default geometry and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package corr_pkg;

    localparam int CORR_DATA_W   = 16;
    localparam int CORR_NUM_LAGS = 8;
    localparam int CORR_ACC_W    = 40;

    // ACCUM takes sample pairs, DUMP streams one result beat per lag
    typedef enum logic {
        ACCUM = 1'b0,
        DUMP  = 1'b1
    } corr_state_t;

endpackage

// File: rtl/corr_lag_mac.sv
// One lag's multiply-accumulate with clamping at the accumulator bounds and a sticky saturation flag.
// Latency: accumulator reflects an enabled product on the next clock edge.
// Backpressure: none; the caller gates i_en with pair acceptance.
module corr_lag_mac
    import corr_pkg::*;
#(
    parameter int DATA_W = CORR_DATA_W,
    parameter int ACC_W  = CORR_ACC_W,
    parameter int SIGNED = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_sat
);

    localparam int   PROD_W = 2 * DATA_W;
    localparam logic SX     = (SIGNED != 0);
    localparam logic [ACC_W-1:0] MAX_S = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] MIN_S = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] MAX_U = {ACC_W{1'b1}};

    logic [ACC_W-1:0]  r_acc;
    logic              r_sat;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]    w_prod_ext;
    logic [ACC_W:0]    w_acc_ext;
    logic [ACC_W:0]    w_sum;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_ovf;

    // Full-width product; operands are widened first so the low PROD_W bits are exact for both signednesses,
    // then the sum is formed one bit wider than the accumulator so overflow is visible in the top two bits.
    always_comb begin
        w_a_ext    = {{DATA_W{i_a[DATA_W-1] & SX}}, i_a};
        w_b_ext    = {{DATA_W{i_b[DATA_W-1] & SX}}, i_b};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = {{(ACC_W+1-PROD_W){w_prod[PROD_W-1] & SX}}, w_prod};
        w_acc_ext  = {r_acc[ACC_W-1] & SX, r_acc};
        w_sum      = w_acc_ext + w_prod_ext;
        w_ovf      = 1'b0;
        w_acc_nxt  = w_sum[ACC_W-1:0];
        if (SX) begin
            if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                w_ovf     = 1'b1;
                w_acc_nxt = w_sum[ACC_W] ? MIN_S : MAX_S;
            end
        end else if (w_sum[ACC_W]) begin
            w_ovf     = 1'b1;
            w_acc_nxt = MAX_U;
        end
    end

    // Accumulator and sticky flag; frame-end clear wins over accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_acc_nxt;
            r_sat <= r_sat | w_ovf;
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule

// File: rtl/corr_lag_engine.sv
// Cross-correlates a probe stream against a reference stream over NUM_LAGS lags per tlast-delimited frame.
// Latency: results start the cycle after the tlast pair is accepted; one beat per lag thereafter.
// Backpressure: inputs stall while either side is invalid or while dumping; dump holds beats on res tready low.
module corr_lag_engine
    import corr_pkg::*;
#(
    parameter int DATA_W   = CORR_DATA_W,
    parameter int NUM_LAGS = CORR_NUM_LAGS,
    parameter int ACC_W    = CORR_ACC_W,
    parameter int SIGNED   = 1
)(
    input  logic              sclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] sig1_axis_tdata,
    input  logic              sig1_axis_tvalid,
    output logic              sig1_axis_tready,
    input  logic [DATA_W-1:0] sig2_axis_tdata,
    input  logic              sig2_axis_tvalid,
    output logic              sig2_axis_tready,
    input  logic              sig2_axis_tlast,
    output logic [ACC_W-1:0]  res_axis_tdata,
    output logic              res_axis_tvalid,
    input  logic              res_axis_tready,
    output logic              res_axis_tlast,
    output logic              res_axis_tuser
);

    // NUM_LAGS must be at least 2: the delay line holds taps 1..NUM_LAGS-1
    localparam int IDX_W = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAGS - 1);

    corr_state_t       r_state;
    corr_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_dly [NUM_LAGS-1];
    logic [DATA_W-1:0] w_tap [NUM_LAGS];
    logic [ACC_W-1:0]  w_acc [NUM_LAGS];
    logic [NUM_LAGS-1:0] w_sat;
    logic [IDX_W-1:0]  r_idx;
    logic              w_accept;
    logic              w_res_hs;
    logic              w_dump_done;

    assign w_accept    = (r_state == ACCUM) && sig1_axis_tvalid && sig2_axis_tvalid;
    assign w_res_hs    = (r_state == DUMP) && res_axis_tready;
    assign w_dump_done = w_res_hs && (r_idx == LAST_IDX);

    // State register
    always_ff @(posedge sclk or posedge areset) begin
        if (areset) r_state <= ACCUM;
        else        r_state <= w_state_nxt;
    end

    // Next state: the tlast pair is still accumulated, the dump ends on the last lag's handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCUM:   if (w_accept && sig2_axis_tlast) w_state_nxt = DUMP;
            DUMP:    if (w_dump_done)                 w_state_nxt = ACCUM;
            default: w_state_nxt = ACCUM;
        endcase
    end

    // Outputs: each tready mirrors the other side's tvalid so a pair moves atomically; all quiet in reset
    always_comb begin
        sig1_axis_tready = 1'b0;
        sig2_axis_tready = 1'b0;
        res_axis_tvalid  = 1'b0;
        res_axis_tdata   = '0;
        res_axis_tuser   = 1'b0;
        res_axis_tlast   = 1'b0;
        if (!areset) begin
            case (r_state)
                ACCUM: begin
                    sig1_axis_tready = sig2_axis_tvalid;
                    sig2_axis_tready = sig1_axis_tvalid;
                end
                DUMP: begin
                    res_axis_tvalid = 1'b1;
                    res_axis_tdata  = w_acc[r_idx];
                    res_axis_tuser  = w_sat[r_idx];
                    res_axis_tlast  = (r_idx == LAST_IDX);
                end
                default: ;
            endcase
        end
    end

    // Tap 0 is the live reference sample; older taps come from the delay line
    always_comb begin
        w_tap[0] = sig1_axis_tdata;
        for (int k = 1; k < NUM_LAGS; k++) w_tap[k] = r_dly[k-1];
    end

    // Reference delay line, shifted only on accepted pairs and emptied between frames
    always_ff @(posedge sclk or posedge areset) begin
        if (areset) begin
            for (int j = 0; j < NUM_LAGS-1; j++) r_dly[j] <= '0;
        end else if (w_dump_done) begin
            for (int j = 0; j < NUM_LAGS-1; j++) r_dly[j] <= '0;
        end else if (w_accept) begin
            r_dly[0] <= sig1_axis_tdata;
            for (int j = 1; j < NUM_LAGS-1; j++) r_dly[j] <= r_dly[j-1];
        end
    end

    // Result index, advanced per result handshake
    always_ff @(posedge sclk or posedge areset) begin
        if (areset)           r_idx <= '0;
        else if (w_dump_done) r_idx <= '0;
        else if (w_res_hs)    r_idx <= r_idx + 1'b1;
    end

    for (genvar g = 0; g < NUM_LAGS; g++) begin : g_lag
        corr_lag_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
        ) u_mac (
            .clk   (sclk),
            .rst   (areset),
            .i_en  (w_accept),
            .i_clr (w_dump_done),
            .i_a   (sig2_axis_tdata),
            .i_b   (w_tap[g]),
            .o_acc (w_acc[g]),
            .o_sat (w_sat[g])
        );
    end

endmodule

// File: tb/tb_corr_lag_engine.sv
// Bench for corr_lag_engine: fixed vectors, stall/gap and reset-in-dump sequences, random frames vs a model.
// Latency: n/a.
// Backpressure: drives gaps on the inputs and stalls on the result stream.
module tb_corr_lag_engine;

    localparam int DW = 16;
    localparam int NL = 4;
    localparam int AW = 32;

    logic          sclk;
    logic          areset;
    logic [DW-1:0] sig1_axis_tdata, sig2_axis_tdata;
    logic          sig1_axis_tvalid, sig1_axis_tready;
    logic          sig2_axis_tvalid, sig2_axis_tready, sig2_axis_tlast;
    logic [AW-1:0] res_axis_tdata;
    logic          res_axis_tvalid, res_axis_tready, res_axis_tlast, res_axis_tuser;

    corr_lag_engine #(.DATA_W(DW), .NUM_LAGS(NL), .ACC_W(AW), .SIGNED(1)) dut (
        .sclk             (sclk),
        .areset           (areset),
        .sig1_axis_tdata  (sig1_axis_tdata),
        .sig1_axis_tvalid (sig1_axis_tvalid),
        .sig1_axis_tready (sig1_axis_tready),
        .sig2_axis_tdata  (sig2_axis_tdata),
        .sig2_axis_tvalid (sig2_axis_tvalid),
        .sig2_axis_tready (sig2_axis_tready),
        .sig2_axis_tlast  (sig2_axis_tlast),
        .res_axis_tdata   (res_axis_tdata),
        .res_axis_tvalid  (res_axis_tvalid),
        .res_axis_tready  (res_axis_tready),
        .res_axis_tlast   (res_axis_tlast),
        .res_axis_tuser   (res_axis_tuser)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [3:0]        n;
        logic [7:0][15:0]  s1;
        logic [7:0][15:0]  s2;
        logic [3:0][31:0]  dat;
        logic [3:0]        sat;
    } vec_t;

    vec_t        vecs [4];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] q_s1 [$];
    logic [15:0] q_s2 [$];
    logic [31:0] e_dat [NL];
    logic        e_sat [NL];
    logic [31:0] g_dat [NL];
    logic        g_usr [NL];
    logic        g_lst [NL];
    logic        gap_bad, tr_bad, hold_bad, stale_bad;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain correlation sum per lag, clamped to 32-bit signed range after every pair
    task automatic model_frame();
        for (int k = 0; k < NL; k++) begin
            longint acc = 0;
            logic   sat = 1'b0;
            for (int n = k; n < q_s1.size(); n++) begin
                acc += longint'($signed(q_s2[n])) * longint'($signed(q_s1[n-k]));
                if (acc > 64'sh7FFF_FFFF)       begin acc = 64'sh7FFF_FFFF;  sat = 1'b1; end
                if (acc < -64'sh8000_0000)      begin acc = -64'sh8000_0000; sat = 1'b1; end
            end
            e_dat[k] = acc[31:0];
            e_sat[k] = sat;
        end
    endtask

    // Send the queued frame; before pair gap_at, hold sig2 invalid for gap_len cycles
    task automatic send_frame(input int gap_at, input int gap_len, input bit hold);
        int waited;
        for (int i = 0; i < q_s1.size(); i++) begin
            if (i == gap_at) begin
                for (int c = 0; c < gap_len; c++) begin
                    @(negedge sclk);
                    sig1_axis_tvalid = 1'b1; sig1_axis_tdata = q_s1[i];
                    sig2_axis_tvalid = 1'b0; sig2_axis_tlast = 1'b0;
                    #1;
                    if (sig1_axis_tready) gap_bad = 1'b1;
                end
            end
            @(negedge sclk);
            sig1_axis_tvalid = 1'b1; sig1_axis_tdata = q_s1[i];
            sig2_axis_tvalid = 1'b1; sig2_axis_tdata = q_s2[i];
            sig2_axis_tlast  = (i == q_s1.size() - 1);
            #1;
            waited = 0;
            while (!(sig1_axis_tready && sig2_axis_tready) && waited < 20) begin
                @(negedge sclk); #1; waited++;
            end
            if (waited >= 20) check("accept_timeout", 64'd1, 64'd0);
        end
        @(negedge sclk);
        sig2_axis_tlast  = 1'b0;
        sig1_axis_tvalid = hold;
        sig2_axis_tvalid = hold;
        sig1_axis_tdata  = 16'h1234;
        sig2_axis_tdata  = 16'h4321;
    endtask

    // Collect NL result beats; stall_beat holds tready low for 3 cycles on that beat
    task automatic collect(input int stall_beat);
        int cnt = 0, stall = 0, cyc = 0;
        logic [33:0] held = '0;
        while (cnt < NL && cyc < 60) begin
            @(negedge sclk);
            res_axis_tready = !(cnt == stall_beat && stall < 3);
            #1;
            if (res_axis_tvalid) begin
                if (sig1_axis_tready || sig2_axis_tready) tr_bad = 1'b1;
                if (cnt == stall_beat && stall > 0 && held !== {res_axis_tdata, res_axis_tuser, res_axis_tlast})
                    hold_bad = 1'b1;
                if (!res_axis_tready) begin
                    if (stall == 0) held = {res_axis_tdata, res_axis_tuser, res_axis_tlast};
                    stall++;
                end else begin
                    g_dat[cnt] = res_axis_tdata;
                    g_usr[cnt] = res_axis_tuser;
                    g_lst[cnt] = res_axis_tlast;
                    cnt++;
                end
            end
            cyc++;
        end
        if (cyc >= 60) check("dump_timeout", 64'd1, 64'd0);
        @(negedge sclk);
        res_axis_tready  = 1'b0;
        sig1_axis_tvalid = 1'b0;
        sig2_axis_tvalid = 1'b0;
        #1;
        check("post_dump_idle", {63'd0, res_axis_tvalid}, 64'd0);
    endtask

    task automatic compare_frame(input string name);
        for (int k = 0; k < NL; k++) begin
            check($sformatf("%s_dat%0d", name, k), {32'd0, g_dat[k]}, {32'd0, e_dat[k]});
            check($sformatf("%s_usr%0d", name, k), {63'd0, g_usr[k]}, {63'd0, e_sat[k]});
            check($sformatf("%s_lst%0d", name, k), {63'd0, g_lst[k]}, {63'd0, (k == NL-1)});
        end
    endtask

    task automatic load_vec(input int v);
        q_s1.delete(); q_s2.delete();
        for (int j = 0; j < int'(vecs[v].n); j++) begin
            q_s1.push_back(vecs[v].s1[j]);
            q_s2.push_back(vecs[v].s2[j]);
        end
        for (int k = 0; k < NL; k++) begin
            e_dat[k] = vecs[v].dat[k];
            e_sat[k] = vecs[v].sat[k];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table: all-ones ramp, negative probe, saturation, single-pair frame
        vecs[0] = '0; vecs[0].n = 4;
        for (int j = 0; j < 4; j++) begin vecs[0].s1[j] = 16'd1; vecs[0].s2[j] = 16'd1; end
        vecs[0].dat[0] = 32'd4; vecs[0].dat[1] = 32'd3; vecs[0].dat[2] = 32'd2; vecs[0].dat[3] = 32'd1;
        vecs[1] = '0; vecs[1].n = 3;
        for (int j = 0; j < 3; j++) begin vecs[1].s1[j] = 16'(j + 1); vecs[1].s2[j] = 16'hFFFF; end
        vecs[1].dat[0] = 32'hFFFF_FFFA; vecs[1].dat[1] = 32'hFFFF_FFFD; vecs[1].dat[2] = 32'hFFFF_FFFF;
        vecs[2] = '0; vecs[2].n = 3;
        for (int j = 0; j < 3; j++) begin vecs[2].s1[j] = 16'h7FFF; vecs[2].s2[j] = 16'h7FFF; end
        vecs[2].dat[0] = 32'h7FFF_FFFF; vecs[2].dat[1] = 32'h7FFE_0002; vecs[2].dat[2] = 32'h3FFF_0001;
        vecs[2].sat[0] = 1'b1;
        vecs[3] = '0; vecs[3].n = 1; vecs[3].s1[0] = 16'd5; vecs[3].s2[0] = 16'hFFFD;
        vecs[3].dat[0] = 32'hFFFF_FFF1;

        gap_bad = 0; tr_bad = 0; hold_bad = 0; stale_bad = 0;
        res_axis_tready = 1'b0;
        sig1_axis_tdata = '0; sig2_axis_tdata = '0; sig2_axis_tlast = 1'b0;

        // Reset: inputs valid, yet every output must stay low
        areset = 1'b1; sig1_axis_tvalid = 1'b1; sig2_axis_tvalid = 1'b1;
        repeat (2) @(negedge sclk);
        #1;
        check("rst_sig1_rdy", {63'd0, sig1_axis_tready}, 64'd0);
        check("rst_sig2_rdy", {63'd0, sig2_axis_tready}, 64'd0);
        check("rst_res_vld",  {63'd0, res_axis_tvalid},  64'd0);
        check("rst_res_dat",  {32'd0, res_axis_tdata},   64'd0);
        check("rst_res_last", {62'd0, res_axis_tlast, res_axis_tuser}, 64'd0);
        @(negedge sclk);
        areset = 1'b0; sig1_axis_tvalid = 1'b0; sig2_axis_tvalid = 1'b0;

        for (int v = 0; v < 4; v++) begin
            load_vec(v);
            send_frame(-1, 0, 1'b0);
            collect(-1);
            compare_frame($sformatf("vec%0d", v));
        end

        // Input gap mid-frame, result stall on beat 2, inputs kept valid throughout the dump
        load_vec(0);
        send_frame(2, 3, 1'b1);
        collect(2);
        compare_frame("gapstall");
        check("gap_no_accept",  {63'd0, gap_bad},  64'd0);
        check("dump_treadys_0", {63'd0, tr_bad},   64'd0);
        check("stall_held",     {63'd0, hold_bad}, 64'd0);

        // Reset while the dump sits at lag 1, then a fresh frame
        load_vec(0);
        send_frame(-1, 0, 1'b0);
        res_axis_tready = 1'b1;
        @(negedge sclk);
        res_axis_tready = 1'b0;
        #1;
        check("pre_rst_idx1", {31'd0, res_axis_tvalid, res_axis_tdata}, {31'd0, 1'b1, 32'd3});
        areset = 1'b1; sig1_axis_tvalid = 1'b1; sig2_axis_tvalid = 1'b1;
        #1;
        check("rst_dump_rdy", {62'd0, sig1_axis_tready, sig2_axis_tready}, 64'd0);
        check("rst_dump_vld", {63'd0, res_axis_tvalid}, 64'd0);
        repeat (2) @(negedge sclk);
        areset = 1'b0; sig1_axis_tvalid = 1'b0; sig2_axis_tvalid = 1'b0; res_axis_tready = 1'b1;
        repeat (5) begin
            #1;
            if (res_axis_tvalid) stale_bad = 1'b1;
            @(negedge sclk);
        end
        res_axis_tready = 1'b0;
        check("no_stale_beats", {63'd0, stale_bad}, 64'd0);
        load_vec(1);
        send_frame(-1, 0, 1'b0);
        collect(-1);
        compare_frame("after_rst");

        // Random frames against the reference model
        for (int f = 0; f < 10; f++) begin
            int n;
            n = $urandom_range(1, 8);
            q_s1.delete(); q_s2.delete();
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    q_s1.push_back(16'($urandom));
                    q_s2.push_back(16'($urandom));
                end else begin
                    q_s1.push_back(16'($urandom_range(0, 15) - 8));
                    q_s2.push_back(16'($urandom_range(0, 15) - 8));
                end
            end
            model_frame();
            send_frame($urandom_range(0, n - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            collect($urandom_range(0, NL));
            compare_frame($sformatf("rnd%0d", f));
        end
        check("rnd_dump_treadys_0", {63'd0, tr_bad},   64'd0);
        check("rnd_stall_held",     {63'd0, hold_bad}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
